// File: rtl/mem_wb_stage_pkg.sv
// Shared load-type codes and writeback state encoding
// for the MEM->WB stage of the MIPS core.
package mem_wb_stage_pkg;

    localparam int LTW = 3;

    localparam logic [LTW-1:0] LT_LW  = 3'd0;
    localparam logic [LTW-1:0] LT_LB  = 3'd1;
    localparam logic [LTW-1:0] LT_LBU = 3'd2;
    localparam logic [LTW-1:0] LT_LH  = 3'd3;
    localparam logic [LTW-1:0] LT_LHU = 3'd4;
    localparam logic [LTW-1:0] LT_LWL = 3'd5;
    localparam logic [LTW-1:0] LT_LWR = 3'd6;

    typedef enum logic [1:0] {
        WB_EMPTY,
        WB_READY,
        WB_WAIT,
        WB_DRAIN
    } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment: byte/half extraction with
// sign/zero extension and LWL/LWR merge with old rt.
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [LTW-1:0] load_type,
    input  logic [1:0]     off,
    input  logic [DW-1:0]  rdata,
    input  logic [DW-1:0]  rt_val,
    output logic [DW-1:0]  result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        result = rdata;
        case (load_type)
            LT_LB:  result = {{24{byte_v[7]}}, byte_v};
            LT_LBU: result = {24'd0, byte_v};
            LT_LH:  result = {{16{half_v[15]}}, half_v};
            LT_LHU: result = {16'd0, half_v};
            LT_LWL: begin
                case (off)
                    2'd0: result = {rdata[7:0], rt_val[23:0]};
                    2'd1: result = {rdata[15:0], rt_val[15:0]};
                    2'd2: result = {rdata[23:0], rt_val[7:0]};
                    default: result = rdata;
                endcase
            end
            LT_LWR: begin
                case (off)
                    2'd1: result = {rt_val[31:24], rdata[31:8]};
                    2'd2: result = {rt_val[31:16], rdata[31:16]};
                    2'd3: result = {rt_val[31:8], rdata[31:24]};
                    default: result = rdata;
                endcase
            end
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and writeback: holds loads
// until the read response, drives regfile and trace bus.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           valid_m,
    input  logic           reg_write_m,
    input  logic           mem_to_reg_m,
    input  logic [4:0]     write_reg_m,
    input  logic [DW-1:0]  alu_out_m,
    input  logic [LTW-1:0] load_type_m,
    input  logic [DW-1:0]  rt_val_m,
    input  logic [DW-1:0]  pc_m,
    input  logic           flush_m,
    input  logic           req_issued_m,
    input  logic           data_ok,
    input  logic [DW-1:0]  rdata,
    output logic           stall_w,
    output logic           RegWriteW,
    output logic [4:0]     WriteRegW,
    output logic [DW-1:0]  ResultW,
    output logic [DW-1:0]  debug_wb_pc,
    output logic [3:0]     debug_wb_rf_wen,
    output logic [4:0]     debug_wb_rf_wnum,
    output logic [DW-1:0]  debug_wb_rf_wdata
);

    wb_state_e      state_q;
    logic           reg_write_q;
    logic [4:0]     write_reg_q;
    logic [DW-1:0]  alu_out_q;
    logic [LTW-1:0] load_type_q;
    logic [DW-1:0]  rt_val_q;
    logic [DW-1:0]  pc_q;
    logic [DW-1:0]  load_data;
    logic           wen_ok;
    logic           busy;

    load_align #(.DW(DW)) u_align (
        .load_type (load_type_q),
        .off       (alu_out_q[1:0]),
        .rdata     (rdata),
        .rt_val    (rt_val_q),
        .result    (load_data)
    );

    assign wen_ok = reg_write_q & (write_reg_q != 5'd0);
    assign busy   = (state_q == WB_WAIT)
                  | (state_q == WB_DRAIN);

    always_comb begin
        stall_w   = busy & ~data_ok;
        RegWriteW = wen_ok
                  & ((state_q == WB_READY)
                  | ((state_q == WB_WAIT) & data_ok));
        WriteRegW = write_reg_q;
        ResultW   = (state_q == WB_WAIT) ? load_data
                                         : alu_out_q;
    end

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wen   = RegWriteW ? 4'hf : 4'h0;
    assign debug_wb_rf_wnum  = WriteRegW;
    assign debug_wb_rf_wdata = ResultW;

    // Killed loads with an issued request park in DRAIN so the
    // stale response is not taken by the next load.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= WB_EMPTY;
            reg_write_q <= 1'b0;
            write_reg_q <= 5'd0;
            alu_out_q   <= '0;
            load_type_q <= '0;
            rt_val_q    <= '0;
            pc_q        <= '0;
        end else if (!stall_w) begin
            reg_write_q <= reg_write_m;
            write_reg_q <= write_reg_m;
            alu_out_q   <= alu_out_m;
            load_type_q <= load_type_m;
            rt_val_q    <= rt_val_m;
            pc_q        <= pc_m;
            if (valid_m && !flush_m)
                state_q <= mem_to_reg_m ? WB_WAIT : WB_READY;
            else if (flush_m && req_issued_m && mem_to_reg_m)
                state_q <= WB_DRAIN;
            else
                state_q <= WB_EMPTY;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed steps
// followed by random traffic against a behavioural model.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_m, reg_write_m, mem_to_reg_m;
    logic [4:0]  write_reg_m;
    logic [31:0] alu_out_m, rt_val_m, pc_m, rdata;
    logic [2:0]  load_type_m;
    logic        flush_m, req_issued_m, data_ok;
    logic        stall_w, RegWriteW;
    logic [4:0]  WriteRegW, debug_wb_rf_wnum;
    logic [31:0] ResultW, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;

    int n_assert = 0;
    int n_fail   = 0;

    // model: 0 none, 1 alu op, 2 load waiting, 3 killed load
    int          kind = 0;
    logic        mrw = 0;
    logic [4:0]  mwr = 0;
    logic [31:0] malu = 0, mrt = 0, mpc = 0;
    logic [2:0]  mlt = 0;

    always #5 clock = ~clock;

    mem_wb_stage dut (
        .clock             (clock),
        .reset             (reset),
        .valid_m           (valid_m),
        .reg_write_m       (reg_write_m),
        .mem_to_reg_m      (mem_to_reg_m),
        .write_reg_m       (write_reg_m),
        .alu_out_m         (alu_out_m),
        .load_type_m       (load_type_m),
        .rt_val_m          (rt_val_m),
        .pc_m              (pc_m),
        .flush_m           (flush_m),
        .req_issued_m      (req_issued_m),
        .data_ok           (data_ok),
        .rdata             (rdata),
        .stall_w           (stall_w),
        .RegWriteW         (RegWriteW),
        .WriteRegW         (WriteRegW),
        .ResultW           (ResultW),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    function automatic logic [31:0] ref_load(
        input logic [2:0]  lt,
        input int          off,
        input logic [31:0] rd,
        input logic [31:0] rt
    );
        int          b, h, sh;
        logic [63:0] w;
        b = int'((rd >> (8 * off)) & 32'hff);
        h = int'((rd >> (16 * (off / 2))) & 32'hffff);
        case (lt)
            LT_LB:  return 32'((b >= 128) ? b - 256 : b);
            LT_LBU: return 32'(b);
            LT_LH:  return 32'((h >= 32768) ? h - 65536 : h);
            LT_LHU: return 32'(h);
            LT_LWL: begin
                sh = 8 * (3 - off);
                w = ({32'd0, rd} << sh)
                  | ({32'd0, rt} & ((64'd1 << sh) - 64'd1));
                return w[31:0];
            end
            LT_LWR: begin
                sh = 8 * off;
                w = {32'd0, 32'hffff_ffff};
                w = w >> sh;
                return (rd >> sh) | (rt & ~w[31:0]);
            end
            default: return rd;
        endcase
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic drive(
        input logic        v,
        input logic        rw,
        input logic        m2r,
        input logic [4:0]  wr,
        input logic [31:0] alu,
        input logic [2:0]  lt,
        input logic [31:0] rt,
        input logic [31:0] pc,
        input logic        fl,
        input logic        ri
    );
        valid_m = v; reg_write_m = rw; mem_to_reg_m = m2r;
        write_reg_m = wr; alu_out_m = alu;
        load_type_m = lt; rt_val_m = rt; pc_m = pc;
        flush_m = fl; req_issued_m = ri;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, LT_LW, 0, 0, 0, 0);
    endtask

    // Check one cycle against the model, then advance it.
    task automatic tick();
        logic        e_stall, e_wen;
        logic [31:0] e_res;
        #1;
        e_stall = (kind == 2 || kind == 3) && !data_ok;
        e_wen = mrw && (mwr != 0)
              && (kind == 1 || (kind == 2 && data_ok));
        e_res = (kind == 2)
              ? ref_load(mlt, int'(malu[1:0]), rdata, mrt)
              : malu;
        chk("stall_w", 32'(stall_w), 32'(e_stall));
        chk("RegWriteW", 32'(RegWriteW), 32'(e_wen));
        chk("dbg_wen", 32'(debug_wb_rf_wen),
            e_wen ? 32'hf : 32'h0);
        chk("dbg_pc", debug_wb_pc, mpc);
        if (e_wen) begin
            chk("WriteRegW", 32'(WriteRegW), 32'(mwr));
            chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(mwr));
            chk("ResultW", ResultW, e_res);
            chk("dbg_wdata", debug_wb_rf_wdata, e_res);
        end
        if (!reset) begin
            kind = 0; mrw = 0; mwr = 0;
            malu = 0; mrt = 0; mpc = 0; mlt = 0;
        end else if (!e_stall) begin
            mrw = reg_write_m; mwr = write_reg_m;
            malu = alu_out_m; mrt = rt_val_m;
            mpc = pc_m; mlt = load_type_m;
            if (valid_m && !flush_m)
                kind = mem_to_reg_m ? 2 : 1;
            else if (flush_m && req_issued_m && mem_to_reg_m)
                kind = 3;
            else
                kind = 0;
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0; data_ok = 1'b0; rdata = '0;
        idle();
        @(negedge clock);
        tick();
        tick();
        #1;
        chk("rst_result", ResultW, 32'h0);
        chk("rst_wreg", 32'(WriteRegW), 32'h0);
        reset = 1'b1;

        // ADDU $3
        drive(1, 1, 0, 3, 32'h1234, LT_LW, 0, 32'h100, 0, 0);
        tick();
        idle();
        #1;
        chk("addu_res", ResultW, 32'h1234);
        tick();

        // LB $4 off 2, response 3 cycles later
        drive(1, 1, 1, 4, 32'h2002, LT_LB, 0, 32'h104, 0, 0);
        tick();
        idle();
        repeat (3) tick();
        data_ok = 1; rdata = 32'h0080_0000;
        #1;
        chk("lb_res", ResultW, 32'hffff_ff80);
        tick();

        // LWL off1 then LWR off2, back-to-back
        data_ok = 0;
        drive(1, 1, 1, 5, 32'h3001, LT_LWL,
              32'haabb_ccdd, 32'h108, 0, 0);
        tick();
        drive(1, 1, 1, 6, 32'h3002, LT_LWR,
              32'haabb_ccdd, 32'h10c, 0, 0);
        data_ok = 1; rdata = 32'h1122_3344;
        #1;
        chk("lwl_res", ResultW, 32'h3344_ccdd);
        tick();
        idle();
        #1;
        chk("lwr_res", ResultW, 32'haabb_1122);
        tick();

        // killed load with issued request, then ADDU $7
        data_ok = 0;
        drive(1, 1, 1, 8, 32'h4000, LT_LW, 0, 32'h110, 1, 1);
        tick();
        idle();
        repeat (2) tick();
        data_ok = 1; rdata = 32'hdead_beef;
        drive(1, 1, 0, 7, 32'h77, LT_LW, 0, 32'h114, 0, 0);
        tick();
        data_ok = 0;
        idle();
        tick();

        // ADDU $0
        drive(1, 1, 0, 0, 32'h55, LT_LW, 0, 32'h118, 0, 0);
        tick();
        idle();
        #1;
        chk("r0_wen", 32'(RegWriteW), 32'h0);
        tick();

        // reset during WAIT
        drive(1, 1, 1, 9, 32'h5000, LT_LW, 0, 32'h11c, 0, 0);
        tick();
        idle();
        reset = 0;
        tick();
        reset = 1;
        #1;
        chk("rw_stall", 32'(stall_w), 32'h0);
        chk("rw_res", ResultW, 32'h0);
        chk("rw_pc", debug_wb_pc, 32'h0);
        tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(99) != 0);
            drive($urandom_range(3) != 0,
                  $urandom_range(4) != 0,
                  $urandom_range(1) == 1,
                  5'($urandom_range(31)),
                  $urandom,
                  3'($urandom_range(6)),
                  $urandom, $urandom,
                  $urandom_range(4) == 0,
                  $urandom_range(1) == 1);
            data_ok = (kind == 2 || kind == 3)
                    && ($urandom_range(2) == 0);
            rdata = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM→WB pipeline register and writeback stage of the 5-stage MIPS core on the AXI SoC.
- Holds the instruction in WB and waits for the data-side read response on loads.
- Aligns and extends load data, including LWL/LWR merge.
- Drives the register-file write port (RegWriteW/WriteRegW/ResultW), the hazard-unit stall and the trace-compare debug bus.

Parameters:
- DW, 32, datapath width.
- LTW, 3, load-type code width.

Ports:
- clock  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; asserted when reset == `RESETABLE (1'b0).
- valid_m  in  1  MEM holds a valid instruction.
- reg_write_m  in  1  instruction writes a GPR.
- mem_to_reg_m  in  1  instruction is a load.
- write_reg_m  in  5  destination GPR.
- alu_out_m  in  DW  ALU result; low 2 bits give the load byte offset.
- load_type_m  in  LTW  LW/LB/LBU/LH/LHU/LWL/LWR code.
- rt_val_m  in  DW  old rt value, used for the LWL/LWR merge.
- pc_m  in  DW  instruction PC.
- flush_m  in  1  kill the instruction being captured from MEM.
- req_issued_m  in  1  the killed load's read request was already issued.
- data_ok  in  1  read response valid (single cycle).
- rdata  in  DW  read response data.
- stall_w  out  1  WB cannot accept; MEM and upstream must hold.
- RegWriteW  out  1  register-file write enable.
- WriteRegW  out  5  register-file write address.
- ResultW  out  DW  register-file write data.
- debug_wb_pc  out  DW  retiring PC.
- debug_wb_rf_wen  out  4  4'hf when RegWriteW, else 0.
- debug_wb_rf_wnum  out  5  equals WriteRegW.
- debug_wb_rf_wdata  out  DW  equals ResultW.

Behaviour:
- States: EMPTY, READY (non-load held), WAIT (load awaiting data_ok), DRAIN (killed load's response outstanding).
- Reset: state EMPTY, all pipeline registers 0. Outputs: stall_w=0, RegWriteW=0, WriteRegW=0, ResultW=0, debug_wb_pc=0.
- Capture: on a clock edge with stall_w=0, the stage loads the MEM fields.
  - valid_m=1, flush_m=0, mem_to_reg_m=1 → WAIT.
  - valid_m=1, flush_m=0, mem_to_reg_m=0 → READY.
  - flush_m=1 with req_issued_m=1 and mem_to_reg_m=1 → DRAIN.
  - Otherwise → EMPTY.
- READY: RegWriteW = reg_write_q & (write_reg_q != 0); ResultW = alu_out_q. Retires in exactly 1 cycle.
- WAIT:
  - data_ok=0: stall_w=1, RegWriteW=0.
  - data_ok=1: combinational write the same cycle, stall_w=0; RegWriteW = reg_write_q & (write_reg_q != 0); ResultW = align(rdata). Next state from capture rules.
  - No added latency beyond the response.
- DRAIN: stall_w=1 and RegWriteW=0 until data_ok. rdata is discarded. On data_ok, stall_w=0 and capture proceeds that edge. This preserves response ordering.
- data_ok in EMPTY/READY: protocol violation, ignored; the bench asserts it never occurs.
- Write to $0: RegWriteW=0 and debug_wen=0. The trace never shows $0 writes.
- Load alignment, with off = alu_out_q[1:0], little-endian:
  - LW: rdata.
  - LB/LBU: byte[off], sign-/zero-extended.
  - LH/LHU: half[off[1]], sign-/zero-extended.
  - LWL:
    - off 0: {rdata[7:0], rt[23:0]}
    - off 1: {rdata[15:0], rt[15:0]}
    - off 2: {rdata[23:0], rt[7:0]}
    - off 3: rdata
  - LWR:
    - off 0: rdata
    - off 1: {rt[31:24], rdata[31:8]}
    - off 2: {rt[31:16], rdata[31:16]}
    - off 3: {rt[31:8], rdata[31:24]}
- Reset mid-WAIT/DRAIN: state forced EMPTY; the outstanding response is the bus reset's responsibility.
- Debug bus follows the RegWriteW cycle; debug_wb_pc = pc_q.

Decomposition:
- defines.vh: LT_LW/LT_LB/LT_LBU/LT_LH/LT_LHU/LT_LWL/LT_LWR codes and LTW; state encodings WB_EMPTY/WB_READY/WB_WAIT/WB_DRAIN.
- One combinational sub-module load_align(load_type, off, rdata, rt_val → result).

Test Plan:
- ADDU $3 with alu_out_m=0x0000_1234 → next cycle RegWriteW=1, WriteRegW=3, ResultW=0x1234, stall_w=0, debug_wen=4'hf.
- LB $4, off=2, data_ok 3 cycles later with rdata=0x00_80_00_00 → stall_w=1 for 3 cycles, then RegWriteW=1, ResultW=0xFFFF_FF80 same cycle.
- LWL off=1, rt=0xAABB_CCDD, rdata=0x1122_3344 → ResultW=0x3344_CCDD. LWR off=2, same inputs → ResultW=0xAABB_1122.
- Flushed load with req_issued_m=1, data_ok after 2 cycles → stall_w=1 for 2 cycles, RegWriteW never asserted; following ADDU retires normally.
- ADDU to $0 → RegWriteW=0, debug_wen=0.
- reset=0 during WAIT → next cycle state EMPTY, stall_w=0, RegWriteW=0, all outputs 0.
